paillier_res_collector: RTL and testbench

//  Downstream stage of the Paillier encryption datapath. Captures the N-word (K bits/word) ciphertext

---
 rtl/paillier_pkg.sv | 19 +
 rtl/paillier_res_collector.sv | 126 ++++++++++++
 tb/tb_paillier_res_collector.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier datapath: default word geometry and the
// result-collector state type, also used by the top-level controller.
package paillier_pkg;

    localparam int K_DEFAULT  = 128;
    localparam int N_DEFAULT  = 32;
    localparam int OW_DEFAULT = 32;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Counter width helper: a 1-entry range still needs one bit of storage.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/paillier_res_collector.sv
// Collects one N-word ciphertext frame from the Montgomery stage, then replays it
// to the host as OW-bit valid/ready beats, low word and low bits first.
module paillier_res_collector
    import paillier_pkg::*;
#(
    parameter int K  = K_DEFAULT,
    parameter int N  = N_DEFAULT,
    parameter int OW = OW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [K-1:0]  in_data,
    input  logic          in_valid,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf
);

    localparam int BEATS = K / OW;
    localparam int AW    = clog2_min1(N);
    localparam int BW    = clog2_min1(BEATS);

    localparam logic [AW-1:0] LAST_WORD = AW'(N - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if ((K % OW) != 0) begin : g_width_check
            $error("paillier_res_collector: K (%0d) must be a multiple of OW (%0d)", K, OW);
        end
    endgenerate

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  wr_cnt;
    logic [AW-1:0]  rd_word;
    logic [BW-1:0]  rd_beat;
    logic [K-1:0]   mem [N];
    logic [K-1:0]   cur_word;

    logic           in_drain;
    logic           capture;
    logic           last_word_in;
    logic           beat_xfer;
    logic           frame_xfer;

    // Words arriving while draining (or alongside clr) are never stored.
    assign in_drain     = (state == ST_DRAIN);
    assign capture      = !in_drain && in_valid && !clr;
    assign last_word_in = capture && (wr_cnt == LAST_WORD);

    assign cur_word   = mem[rd_word];
    assign out_valid  = in_drain;
    assign out_last   = in_drain && (rd_word == LAST_WORD) && (rd_beat == LAST_BEAT);
    assign out_data   = in_drain ? cur_word[rd_beat*OW +: OW] : '0;
    assign busy       = in_drain;

    assign beat_xfer  = in_drain && out_ready;
    assign frame_xfer = beat_xfer && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = ST_FILL;
        end else begin
            case (state)
                ST_FILL:  if (last_word_in) state_next = ST_DRAIN;
                ST_DRAIN: if (frame_xfer)   state_next = ST_FILL;
                default:  state_next = ST_FILL;
            endcase
        end
    end

    // Frame storage carries no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            rd_word    <= '0;
            rd_beat    <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else if (clr) begin
            wr_cnt     <= '0;
            rd_word    <= '0;
            rd_beat    <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= frame_xfer;
            if (capture) begin
                wr_cnt <= last_word_in ? '0 : wr_cnt + 1'b1;
            end
            if (in_drain && in_valid) begin
                ovf <= 1'b1;
            end
            // Read pointer walks beats within a word, then words; both wrap to 0 after the last beat.
            if (beat_xfer) begin
                if (rd_beat == LAST_BEAT) begin
                    rd_beat <= '0;
                    rd_word <= (rd_word == LAST_WORD) ? '0 : rd_word + 1'b1;
                end else begin
                    rd_beat <= rd_beat + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paillier_res_collector.sv
// Directed/random bench for paillier_res_collector: frames are built by the bench,
// expected beats are sliced from those words and checked with immediate assertions.
module tb_paillier_res_collector;

    localparam int K     = 128;
    localparam int N     = 32;
    localparam int OW    = 32;
    localparam int BEATS = K / OW;
    localparam int TOTAL = N * BEATS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [K-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          frame_done;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    logic [K-1:0] frame_words [N];

    always #5 clk = ~clk;

    paillier_res_collector #(.K(K), .N(N), .OW(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    task automatic check_output(input string tag, input logic [K-1:0] observed, input logic [K-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Beat idx of the frame: word idx/BEATS, shifted down by its position inside that word.
    function automatic logic [OW-1:0] ref_beat(input int idx);
        logic [K-1:0] word;
        word = frame_words[idx / BEATS];
        return OW'(word >> ((idx % BEATS) * OW));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input bit random_words);
        for (int i = 0; i < N; i++) begin
            if (random_words) begin
                frame_words[i] = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                frame_words[i] = {32'(i*4 + 3), 32'(i*4 + 2), 32'(i*4 + 1), 32'(i*4)};
            end
        end
    endtask

    task automatic apply_stimulus(input int gap);
        int early = 0;
        for (int i = 0; i < N; i++) begin
            in_data  = frame_words[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            in_data  = '0;
            if (i < N - 1) begin
                if (out_valid) early++;
                repeat (gap) begin
                    step();
                    if (out_valid) early++;
                end
            end
        end
        check_output("no_early_valid", K'(early), K'(0));
        check_output("first_beat_latency", K'(out_valid), K'(1));
        check_output("busy_in_drain", K'(busy), K'(1));
    endtask

    // ev_kind: 0 none, 1 in_valid pulse (overflow), 2 clr abort, 3 rst_n abort.
    task automatic drain_and_check(input int pct, input int ev_beat, input int ev_kind, input string tag);
        int beat = 0;
        int cycles = 0;
        logic [OW-1:0] held = '0;
        bit stalled = 1'b0;
        while (beat < TOTAL) begin
            if (cycles > 4000) begin
                check_output({tag, " drain_timeout"}, K'(beat), K'(TOTAL));
                return;
            end
            if (!out_valid) begin
                check_output({tag, " valid_withdrawn"}, K'(out_valid), K'(1));
                return;
            end
            check_output({tag, " beat_data"}, K'(out_data), K'(ref_beat(beat)));
            check_output({tag, " beat_last"}, K'(out_last), K'(beat == TOTAL - 1));
            if (stalled) check_output({tag, " stall_hold"}, K'(out_data), K'(held));
            out_ready = ($urandom_range(99) < pct);
            if (beat == ev_beat && ev_kind == 1) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end else if (beat == ev_beat && ev_kind == 2) begin
                clr = 1'b1;
                out_ready = 1'b1;
                step();
                clr = 1'b0;
                out_ready = 1'b0;
                check_output({tag, " clr_valid"}, K'(out_valid), K'(0));
                check_output({tag, " clr_last"}, K'(out_last), K'(0));
                check_output({tag, " clr_busy"}, K'(busy), K'(0));
                check_output({tag, " clr_no_done"}, K'(frame_done), K'(0));
                step();
                check_output({tag, " clr_no_done2"}, K'(frame_done), K'(0));
                return;
            end else if (beat == ev_beat && ev_kind == 3) begin
                out_ready = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                check_output({tag, " rst_outputs"},
                             K'({out_valid, out_last, busy, frame_done, ovf}), K'(0));
                check_output({tag, " rst_data"}, K'(out_data), K'(0));
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                step();
                check_output({tag, " rst_idle"}, K'({out_valid, busy}), K'(0));
                return;
            end
            held    = out_data;
            stalled = !out_ready;
            step();
            in_valid = 1'b0;
            in_data  = '0;
            if (out_ready) beat++;
            cycles++;
        end
        if (pct >= 100) check_output({tag, " back_to_back"}, K'(cycles), K'(TOTAL));
        out_ready = 1'b0;
        check_output({tag, " frame_done"}, K'(frame_done), K'(1));
        check_output({tag, " idle_after"}, K'({out_valid, busy}), K'(0));
        step();
        check_output({tag, " done_pulse"}, K'(frame_done), K'(0));
    endtask

    initial begin
        $display("[TB] start");
        #12;
        check_output("reset_outputs", K'({out_valid, out_last, busy, frame_done, ovf}), K'(0));
        check_output("reset_data", K'(out_data), K'(0));
        rst_n = 1'b1;
        step();

        // Patterned frame, back-to-back input and output.
        build_frame(1'b0);
        apply_stimulus(0);
        drain_and_check(100, -1, 0, "t1");

        // Same frame with sparse input.
        build_frame(1'b0);
        apply_stimulus(2);
        drain_and_check(100, -1, 0, "t2");

        // Random data, random host backpressure.
        build_frame(1'b1);
        apply_stimulus(0);
        drain_and_check(50, -1, 0, "t3");

        // Overflow during drain, sticky until clr.
        build_frame(1'b1);
        apply_stimulus(0);
        drain_and_check(100, 40, 1, "t4a");
        check_output("t4 ovf_set", K'(ovf), K'(1));
        build_frame(1'b1);
        apply_stimulus(int'($urandom_range(0, 1)));
        drain_and_check(50, -1, 0, "t4b");
        check_output("t4 ovf_sticky", K'(ovf), K'(1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_output("t4 ovf_cleared", K'(ovf), K'(0));

        // Partial frame discarded by clr; the word coinciding with clr is dropped too.
        for (int i = 0; i < 10; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            step();
        end
        clr      = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check_output("t5 clr_fill_idle", K'({out_valid, busy}), K'(0));
        build_frame(1'b1);
        apply_stimulus(0);
        drain_and_check(100, -1, 0, "t5a");
        build_frame(1'b1);
        apply_stimulus(0);
        drain_and_check(100, 50, 2, "t5b");

        // Asynchronous reset mid-drain, then a clean frame.
        build_frame(1'b1);
        apply_stimulus(0);
        drain_and_check(100, 70, 3, "t6a");
        build_frame(1'b1);
        apply_stimulus(1);
        drain_and_check(70, -1, 0, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
